// File: rtl/serial_frame_send.sv
// Serialises a latched byte array into UART writes, optionally framed as
// SOF + payload + XOR checksum, handshaking on the transmitter's busy flag.
module serial_frame_send #(
    parameter int         MAX_BYTES = 16,
    parameter int         CNT_W     = 5,
    parameter int         FRAMED    = 1,
    parameter logic [7:0] SOF       = 8'h7E,
    parameter int         LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*MAX_BYTES-1:0] old_data,
    input  logic [CNT_W-1:0]       count,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   busy,
    output logic                   txdWrite,
    output logic [7:0]             txdData,
    output logic                   arrayBusy,
    output logic                   done,
    output logic                   err
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_NEXT} state_t;
    typedef enum logic [1:0] {PH_SOF, PH_DATA, PH_CSUM} phase_t;

    state_t                 state_q;
    phase_t                 phase_q;
    logic [IDX_W-1:0]       index_q;
    logic [CNT_W-1:0]       count_q;
    logic [8*MAX_BYTES-1:0] data_q;
    logic [7:0]             csum_q;
    logic                   txdWrite_q;
    logic [7:0]             txdData_q;
    logic                   arrayBusy_q;
    logic                   done_q;
    logic                   err_q;

    logic [7:0]             payloadByte;
    logic [7:0]             txdByte_d;
    logic                   countOk;
    logic                   lastByte;

    assign countOk  = (count != '0) && (count <= CNT_W'(MAX_BYTES));
    assign lastByte = (CNT_W'(index_q) == (count_q - CNT_W'(1)));

    // Byte order within the packed payload is fixed at elaboration time.
    always_comb begin
        payloadByte = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (index_q == IDX_W'(i)) begin
                if (LSB_FIRST != 0) payloadByte = data_q[8*i +: 8];
                else                payloadByte = data_q[8*(MAX_BYTES-1-i) +: 8];
            end
        end
    end

    always_comb begin
        txdByte_d = csum_q;
        case (phase_q)
            PH_SOF:  txdByte_d = SOF;
            PH_DATA: txdByte_d = payloadByte;
            default: txdByte_d = csum_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_SOF;
            index_q     <= '0;
            csum_q      <= '0;
            txdWrite_q  <= 1'b0;
            txdData_q   <= '0;
            arrayBusy_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            txdWrite_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (countOk) begin
                            data_q      <= old_data;
                            count_q     <= count;
                            index_q     <= '0;
                            csum_q      <= '0;
                            phase_q     <= (FRAMED != 0) ? PH_SOF : PH_DATA;
                            state_q     <= S_WAIT;
                            arrayBusy_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        arrayBusy_q <= 1'b0;
                    end else if (!busy) begin
                        // Strobe is raised on entry so it spans exactly the WRITE cycle.
                        state_q    <= S_WRITE;
                        txdWrite_q <= 1'b1;
                        txdData_q  <= txdByte_d;
                        if (phase_q == PH_DATA) csum_q <= csum_q ^ txdByte_d;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        arrayBusy_q <= 1'b0;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        arrayBusy_q <= 1'b0;
                    end else begin
                        case (phase_q)
                            PH_SOF: begin
                                phase_q <= PH_DATA;
                                state_q <= S_WAIT;
                            end
                            PH_DATA: begin
                                if (!lastByte) begin
                                    index_q <= index_q + IDX_W'(1);
                                    state_q <= S_WAIT;
                                end else if (FRAMED != 0) begin
                                    phase_q <= PH_CSUM;
                                    state_q <= S_WAIT;
                                end else begin
                                    state_q     <= S_IDLE;
                                    arrayBusy_q <= 1'b0;
                                    done_q      <= 1'b1;
                                end
                            end
                            default: begin
                                state_q     <= S_IDLE;
                                arrayBusy_q <= 1'b0;
                                done_q      <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    arrayBusy_q <= 1'b0;
                end
            endcase
        end
    end

    assign txdWrite  = txdWrite_q;
    assign txdData   = txdData_q;
    assign arrayBusy = arrayBusy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_serial_frame_send.sv
// Directed bench for serial_frame_send: a framed LSB-first instance and an
// unframed MSB-first instance share one stimulus stream.
module tb_serial_frame_send;

    localparam int MAX_BYTES = 16;
    localparam int CNT_W     = 5;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [8*MAX_BYTES-1:0] old_data = '0;
    logic [CNT_W-1:0]       count = '0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   busy = 1'b0;

    logic       txdWrite, arrayBusy, done, err;
    logic [7:0] txdData;
    logic       txdWrite2, arrayBusy2, done2, err2;
    logic [7:0] txdData2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int errSeen = 0;
    logic [7:0] strobeData[$];
    int         strobeStamp[$];
    logic [7:0] strobeData2[$];
    int         doneStamp[$];

    serial_frame_send #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .old_data(old_data), .count(count),
        .start(start), .abort(abort), .busy(busy),
        .txdWrite(txdWrite), .txdData(txdData), .arrayBusy(arrayBusy),
        .done(done), .err(err)
    );

    serial_frame_send #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W), .FRAMED(0), .LSB_FIRST(0)) dut2 (
        .clk(clk), .reset(reset), .old_data(old_data), .count(count),
        .start(start), .abort(abort), .busy(busy),
        .txdWrite(txdWrite2), .txdData(txdData2), .arrayBusy(arrayBusy2),
        .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stamp is the number of the edge that closes the observed cycle.
    always @(negedge clk) begin
        if (txdWrite === 1'b1) begin
            strobeData.push_back(txdData);
            strobeStamp.push_back(cyc + 1);
        end
        if (txdWrite2 === 1'b1) strobeData2.push_back(txdData2);
        if (done === 1'b1) doneStamp.push_back(cyc + 1);
        if (err === 1'b1) errSeen++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8*MAX_BYTES-1:0] d, input logic [CNT_W-1:0] c, output int edgeN);
        old_data = d;
        count    = c;
        start    = 1'b1;
        tick();
        edgeN = cyc;
        start = 1'b0;
    endtask

    task automatic clearLogs();
        strobeData.delete();
        strobeStamp.delete();
        strobeData2.delete();
        doneStamp.delete();
        errSeen = 0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (arrayBusy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic waitStrobes(input int target, input string tag);
        int n = 0;
        while (strobeData.size() < target && n < 100) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(n < 100), 32'd1);
    endtask

    initial begin
        int edgeN;
        int base;
        logic [7:0] exp1 [5];
        logic [7:0] exp3 [5];

        exp1 = '{8'h7E, 8'h11, 8'h22, 8'h44, 8'h77};
        exp3 = '{8'h7E, 8'h0F, 8'hF0, 8'h55, 8'hAA};

        repeat (3) tick();
        checkOutput("rst_txdWrite", 32'(txdWrite), 32'd0);
        checkOutput("rst_txdData", 32'(txdData), 32'd0);
        checkOutput("rst_arrayBusy", 32'(arrayBusy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        repeat (2) tick();
        clearLogs();

        // Framed frame, transmitter always ready.
        applyStimulus({104'h0, 8'h44, 8'h22, 8'h11}, 5'd3, edgeN);
        checkOutput("t1_busy_after_start", 32'(arrayBusy), 32'd1);
        waitIdle("t1_idle_timeout");
        checkOutput("t1_done_with_busy_fall", 32'(done), 32'd1);
        checkOutput("t1_strobe_count", strobeData.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < strobeData.size()) begin
                checkOutput($sformatf("t1_data%0d", i), 32'(strobeData[i]), 32'(exp1[i]));
                checkOutput($sformatf("t1_stamp%0d", i), strobeStamp[i], edgeN + 2 + 3*i);
            end
        end
        checkOutput("t1_done_count", doneStamp.size(), 32'd1);
        if (doneStamp.size() > 0) checkOutput("t1_done_stamp", doneStamp[0], edgeN + 16);
        tick();
        checkOutput("t1_done_one_cycle", 32'(done), 32'd0);
        repeat (4) tick();
        clearLogs();

        // Unframed MSB-first instance sends the top two bytes.
        applyStimulus({8'hA5, 8'h3C, 96'h0, 8'h02, 8'h01}, 5'd2, edgeN);
        waitIdle("t2_idle_timeout");
        repeat (3) tick();
        checkOutput("t2_u_count", strobeData2.size(), 32'd2);
        if (strobeData2.size() >= 2) begin
            checkOutput("t2_u_byte0", 32'(strobeData2[0]), 32'hA5);
            checkOutput("t2_u_byte1", 32'(strobeData2[1]), 32'h3C);
        end
        checkOutput("t2_f_count", strobeData.size(), 32'd4);
        if (strobeData.size() >= 4) checkOutput("t2_f_csum", 32'(strobeData[3]), 32'h03);
        clearLogs();

        // Busy held high for 10 cycles before every byte.
        busy = 1'b1;
        applyStimulus({104'h0, 8'h55, 8'hF0, 8'h0F}, 5'd3, edgeN);
        for (int i = 0; i < 5; i++) begin
            repeat (10) tick();
            checkOutput($sformatf("t3_hold%0d", i), strobeData.size(), i);
            busy = 1'b0;
            tick();
            checkOutput($sformatf("t3_strobe%0d", i), 32'(txdWrite), 32'd1);
            checkOutput($sformatf("t3_data%0d", i), 32'(txdData), 32'(exp3[i]));
            busy = 1'b1;
        end
        busy = 1'b0;
        waitIdle("t3_idle_timeout");
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_total", strobeData.size(), 32'd5);
        repeat (4) tick();
        clearLogs();

        // Rejected starts: zero and oversize counts.
        old_data = '0;
        count = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t4_err_zero", 32'(err), 32'd1);
        checkOutput("t4_busy_zero", 32'(arrayBusy), 32'd0);
        tick();
        checkOutput("t4_err_clear", 32'(err), 32'd0);
        count = 5'(MAX_BYTES + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t4_err_over", 32'(err), 32'd1);
        checkOutput("t4_busy_over", 32'(arrayBusy), 32'd0);
        repeat (4) tick();
        checkOutput("t4_err_pulses", errSeen, 32'd2);
        checkOutput("t4_no_strobes", strobeData.size() + strobeData2.size(), 32'd0);
        clearLogs();

        // Abort while waiting for the third byte, then a fresh frame.
        applyStimulus({104'h0, 8'h44, 8'h22, 8'h11}, 5'd3, edgeN);
        waitStrobes(2, "t5_strobe_timeout");
        busy = 1'b1;
        repeat (2) tick();
        checkOutput("t5_in_frame", 32'(arrayBusy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        busy = 1'b0;
        checkOutput("t5_idle_after_abort", 32'(arrayBusy), 32'd0);
        checkOutput("t5_no_done", 32'(done), 32'd0);
        repeat (10) tick();
        checkOutput("t5_strobe_total", strobeData.size(), 32'd2);
        checkOutput("t5_done_count", doneStamp.size(), 32'd0);
        clearLogs();
        applyStimulus({120'h0, 8'h5A}, 5'd1, edgeN);
        waitIdle("t5_restart_timeout");
        checkOutput("t5_restart_done", 32'(done), 32'd1);
        checkOutput("t5_restart_count", strobeData.size(), 32'd3);
        if (strobeData.size() >= 3) checkOutput("t5_restart_csum", 32'(strobeData[2]), 32'h5A);
        repeat (4) tick();
        clearLogs();

        // Reset mid-frame with start held high throughout.
        applyStimulus({112'h0, 8'h44, 8'h33}, 5'd2, edgeN);
        waitStrobes(2, "t6_strobe_timeout");
        reset = 1'b0;
        start = 1'b1;
        tick();
        checkOutput("t6_txdWrite", 32'(txdWrite), 32'd0);
        checkOutput("t6_txdData", 32'(txdData), 32'd0);
        checkOutput("t6_arrayBusy", 32'(arrayBusy), 32'd0);
        checkOutput("t6_done", 32'(done), 32'd0);
        checkOutput("t6_err", 32'(err), 32'd0);
        tick();
        checkOutput("t6_held_in_reset", 32'(arrayBusy), 32'd0);
        reset = 1'b1;
        tick();
        edgeN = cyc;
        start = 1'b0;
        checkOutput("t6_accept_first_edge", 32'(arrayBusy), 32'd1);
        base = strobeData.size();
        waitIdle("t6_idle_timeout");
        checkOutput("t6_done_after_reset", 32'(done), 32'd1);
        checkOutput("t6_strobe_count", strobeData.size() - base, 32'd4);
        if (strobeData.size() >= base + 4) begin
            checkOutput("t6_first_data", 32'(strobeData[base]), 32'h7E);
            checkOutput("t6_first_stamp", strobeStamp[base], edgeN + 2);
            checkOutput("t6_csum", 32'(strobeData[base + 3]), 32'h77);
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_send.md
SERIAL_FRAME_SEND -- requirements
Module: serial_frame_send

Interface
REQ-001 Parameter MAX_BYTES, default 16: capacity of the payload array in bytes.
REQ-002 Parameter CNT_W, default 5: width of count; SHALL satisfy 2**CNT_W > MAX_BYTES.
REQ-003 Parameter FRAMED, default 1: 1 = wrap the payload as SOF byte, payload, XOR checksum byte; 0 = payload only.
REQ-004 Parameter SOF, default 8'h7E: start-of-frame byte value.
REQ-005 Parameter LSB_FIRST, default 1: 1 = payload byte 0 is data[7:0]; 0 = payload byte 0 is data[8*MAX_BYTES-1 -: 8].
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-008 old_data  in  8*MAX_BYTES  packed payload, sampled only on accepted start.
REQ-009 count  in  CNT_W  payload byte count, unsigned, sampled only on accepted start.
REQ-010 start  in  1  request; considered only in IDLE.
REQ-011 abort  in  1  cancels a frame in progress.
REQ-012 busy  in  1  UART transmitter busy; a byte may be written only while busy==0.
REQ-013 txdWrite  out  1  one-cycle write strobe to the UART.
REQ-014 txdData  out  8  byte presented with txdWrite; holds its last value otherwise.
REQ-015 arrayBusy  out  1  high whenever state != IDLE.
REQ-016 done  out  1  one-cycle pulse on normal frame completion.
REQ-017 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-018 States: IDLE, WAIT, WRITE, NEXT; all outputs registered.
REQ-019 IDLE: start==1 with 1 <= count <= MAX_BYTES -> latch old_data, count; clear index and checksum; set phase = SOF if FRAMED else DATA; go to WAIT.
REQ-020 IDLE: start==1 with count==0 or count>MAX_BYTES -> err=1 for the next cycle; remain in IDLE; nothing latched.
REQ-021 WAIT: busy==0 -> WRITE; busy==1 -> stay in WAIT, indefinitely.
REQ-022 WRITE: txdWrite=1 for exactly this cycle; txdData = SOF (phase SOF), payload byte[index] (phase DATA), or checksum (phase CSUM); go to NEXT.
REQ-023 NEXT: phase SOF -> DATA, go to WAIT.
REQ-024 NEXT: phase DATA with index < count-1 -> index+1, go to WAIT.
REQ-025 NEXT: phase DATA, last payload byte -> phase CSUM if FRAMED and go to WAIT; otherwise go to IDLE.
REQ-026 NEXT: phase CSUM -> go to IDLE.
REQ-027 done SHALL be 1 during the first IDLE cycle after a completed frame, coinciding with arrayBusy falling.
REQ-028 Checksum = XOR of all payload bytes sent, 8 bits, accumulated in WRITE; the SOF byte is excluded.
REQ-029 Latency: start accepted at edge N, busy low -> first txdWrite at cycle N+2; steady state 3 cycles per byte.
REQ-030 Frame length: count+2 strobes if FRAMED, else count strobes; exactly one strobe per byte.
REQ-031 abort==1 in WAIT, WRITE or NEXT -> IDLE at the next edge; no further strobes; done not pulsed. A strobe in the current WRITE cycle completes.
REQ-032 Priority: reset > abort > normal transitions; abort in IDLE is ignored.
REQ-033 start while arrayBusy==1 is ignored; latched data and count stay stable for the whole frame.
REQ-034 Index width: clog2(MAX_BYTES) bits; never wraps within a frame.

Reset
REQ-035 reset==0 -> state IDLE, txdWrite=0, txdData=0, done=0, err=0, index=0, checksum=0, arrayBusy=0 on the following cycle; this applies in any state, including mid-frame.
REQ-036 Latched data and count need not be reset.

Verification
REQ-037 FRAMED=1, count=3, bytes 0x11,0x22,0x44, busy=0 -> txdData 0x7E,0x11,0x22,0x44,0x77; strobes 3 cycles apart; first strobe at N+2; done one cycle after the last NEXT.
REQ-038 FRAMED=0, LSB_FIRST=0, count=2 -> the top two bytes are sent, MSB byte first; exactly 2 strobes; no checksum.
REQ-039 busy held high for 10 cycles before each byte -> no strobe while busy==1; each strobe 1 cycle after busy falls; data order unchanged.
REQ-040 count=0, then count=MAX_BYTES+1 -> err pulses once each; arrayBusy stays 0; no strobes.
REQ-041 abort asserted in WAIT before the third byte -> IDLE next cycle; exactly 2 strobes total; done=0; a new start is accepted afterwards.
REQ-042 reset=0 mid-frame, with start held -> all outputs reset and IDLE; start is accepted only on the first edge with reset==1.
